tt_proj_sel_ctrl: RTL and testbench

//   Chip-level selector/sequencer for the per-project wrappers. Takes a serial address load
//   (clear + increment pulses) and a commit strobe, then switches the project domain safely:
//   - all ena low for a guard period
//   - new project enabled and held in reset
//   - released to run

---
 rtl/tt_proj_sel_pkg.sv | 29 ++
 rtl/tt_proj_sel_edge.sv | 55 +++++
 rtl/tt_proj_sel_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_tt_proj_sel_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tt_proj_sel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tt_proj_sel_pkg
// Description : Shared state encoding and helper functions for the project
//               selector/sequencer (tt_proj_sel_ctrl).
// Revision    : 1.0 - initial release
// ============================================================================
package tt_proj_sel_pkg;

    // Sequencer states: idle, all-enables-low guard, enabled-in-reset, running
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_DRAIN = 2'd1;
    localparam logic [1:0] c_ST_HOLD  = 2'd2;
    localparam logic [1:0] c_ST_RUN   = 2'd3;

    // Width of the phase counter: must hold the larger of the two phase lengths
    function automatic int cnt_width(input int guard_cycles, input int rst_cycles);
        int max_v;
        max_v = (guard_cycles > rst_cycles) ? guard_cycles : rst_cycles;
        return $clog2(max_v + 1);
    endfunction

    // Lane n of a one-hot decode of addr
    function automatic logic onehot(input int addr, input int n);
        return (addr == n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/tt_proj_sel_edge.sv
`default_nettype none
// ============================================================================
// Module      : tt_proj_sel_edge
// Description : Control-input conditioner: optional 2-flop synchronizer
//               (enabled by TT_PROJ_SEL_SYNC_EN) followed by a rising-edge
//               detector. Provides the conditioned level and a one-cycle
//               rise pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module tt_proj_sel_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic i_din,
    output logic o_level,
    output logic o_rise
);

    logic w_level;
    logic r_prev;

`ifdef TT_PROJ_SEL_SYNC_EN
    logic r_meta;
    logic r_sync;

    // Two-flop synchronizer, cleared by reset so no stale edge appears after it
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_din;
            r_sync <= r_meta;
        end
    end

    assign w_level = r_sync;
`else
    // Input is already synchronous to clk and is used as-is
    assign w_level = i_din;
`endif

    // Previous sample of the conditioned level, primed low by reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_prev <= 1'b0;
        end else begin
            r_prev <= w_level;
        end
    end

    assign o_level = w_level;
    assign o_rise  = w_level & ~r_prev;

endmodule
`default_nettype wire

// File: rtl/tt_proj_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tt_proj_sel_ctrl
// Description : Chip-level project selector/sequencer. A pending address is
//               loaded serially (clear level + increment edges); a commit
//               edge switches the project domain via a guard interval with
//               every enable low, then enables the new project while holding
//               the shared reset, then releases it to run.
//               Build option TT_PROJ_SEL_SYNC_EN adds 2-flop synchronizers
//               on all control inputs (+2 cycles on every input effect).
// Revision    : 1.0 - initial release
// ============================================================================
module tt_proj_sel_ctrl
    import tt_proj_sel_pkg::*;
#(
    parameter  int NUM_PROJ     = 24,
    parameter  int GUARD_CYCLES = 2,
    parameter  int RST_CYCLES   = 4,
    localparam int AW           = $clog2(NUM_PROJ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ctrl_ena,
    input  logic                sel_clr,
    input  logic                sel_inc,
    input  logic                sel_commit,
    output logic [NUM_PROJ-1:0] proj_ena,
    output logic                proj_rst_n,
    output logic [AW-1:0]       active_addr,
    output logic [AW-1:0]       pending_addr,
    output logic                busy
);

    localparam int            CW           = cnt_width(GUARD_CYCLES, RST_CYCLES);
    localparam logic [CW-1:0] c_GUARD_LOAD = CW'(GUARD_CYCLES - 1);
    localparam logic [CW-1:0] c_RST_LOAD   = CW'(RST_CYCLES - 1);
    localparam logic [AW-1:0] c_LAST_ADDR  = AW'(NUM_PROJ - 1);

    // ------------------------------------------------------------------------
    // Conditioned control inputs
    // ------------------------------------------------------------------------
    logic w_ena_lvl,    w_ena_rise;
    logic w_clr_lvl,    w_clr_rise;
    logic w_inc_lvl,    w_inc_rise;
    logic w_commit_lvl, w_commit_rise;

    tt_proj_sel_edge u_edge_ena (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_din   (ctrl_ena),
        .o_level (w_ena_lvl),
        .o_rise  (w_ena_rise)
    );

    tt_proj_sel_edge u_edge_clr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_din   (sel_clr),
        .o_level (w_clr_lvl),
        .o_rise  (w_clr_rise)
    );

    tt_proj_sel_edge u_edge_inc (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_din   (sel_inc),
        .o_level (w_inc_lvl),
        .o_rise  (w_inc_rise)
    );

    tt_proj_sel_edge u_edge_commit (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_din   (sel_commit),
        .o_level (w_commit_lvl),
        .o_rise  (w_commit_rise)
    );

    // Only enable level, clear level, increment edge and commit edge matter here
    logic w_unused_edge;
    assign w_unused_edge = ^{w_ena_rise, w_clr_rise, w_inc_lvl, w_commit_lvl};

    // A commit only counts while the block is globally enabled
    logic w_commit;
    assign w_commit = w_commit_rise & w_ena_lvl;

    // ------------------------------------------------------------------------
    // Pending address (independent of sequencer state)
    // ------------------------------------------------------------------------
    logic [AW-1:0] r_pending;

    // Clear has priority over an increment edge; increment wraps at the last project
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= '0;
        end else if (w_clr_lvl) begin
            r_pending <= '0;
        end else if (w_inc_rise) begin
            r_pending <= (r_pending == c_LAST_ADDR) ? '0 : r_pending + AW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------------
    logic [1:0]    r_state,  w_state_nxt;
    logic [CW-1:0] r_cnt,    w_cnt_nxt;
    logic [AW-1:0] r_target, w_target_nxt;
    logic [AW-1:0] r_active, w_active_nxt;

    // Next-state: disable beats commit, commit beats phase progress from any state
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_target_nxt = r_target;
        w_active_nxt = r_active;
        if (!w_ena_lvl) begin
            w_state_nxt = c_ST_IDLE;
            w_cnt_nxt   = '0;
        end else if (w_commit) begin
            w_state_nxt  = c_ST_DRAIN;
            w_cnt_nxt    = c_GUARD_LOAD;
            w_target_nxt = r_pending;
        end else begin
            case (r_state)
                c_ST_DRAIN: begin
                    if (r_cnt == '0) begin
                        w_state_nxt  = c_ST_HOLD;
                        w_cnt_nxt    = c_RST_LOAD;
                        w_active_nxt = r_target;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
                c_ST_HOLD: begin
                    if (r_cnt == '0) begin
                        w_state_nxt = c_ST_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - CW'(1);
                    end
                end
                default: begin
                    // IDLE and RUN wait for a commit or disable
                end
            endcase
        end
    end

    // One-hot decode of the address that will be active next cycle
    logic [NUM_PROJ-1:0] w_onehot_nxt;

    for (genvar i = 0; i < NUM_PROJ; i++) begin : g_onehot
        assign w_onehot_nxt[i] = onehot(int'(w_active_nxt), i);
    end

    logic                w_ena_on_nxt;
    assign w_ena_on_nxt = (w_state_nxt == c_ST_HOLD) || (w_state_nxt == c_ST_RUN);

    logic [NUM_PROJ-1:0] r_proj_ena;
    logic                r_proj_rst_n;
    logic                r_busy;

    // State, counter and outputs registered from next-state so outputs track the state exactly
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_cnt        <= '0;
            r_target     <= '0;
            r_active     <= '0;
            r_proj_ena   <= '0;
            r_proj_rst_n <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_cnt        <= w_cnt_nxt;
            r_target     <= w_target_nxt;
            r_active     <= w_active_nxt;
            r_proj_ena   <= w_ena_on_nxt ? w_onehot_nxt : '0;
            r_proj_rst_n <= (w_state_nxt == c_ST_RUN);
            r_busy       <= (w_state_nxt == c_ST_DRAIN) || (w_state_nxt == c_ST_HOLD);
        end
    end

    assign proj_ena     = r_proj_ena;
    assign proj_rst_n   = r_proj_rst_n;
    assign active_addr  = r_active;
    assign pending_addr = r_pending;
    assign busy         = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_tt_proj_sel_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_tt_proj_sel_ctrl
// Description : Self-checking bench for tt_proj_sel_ctrl (NUM_PROJ=4,
//               GUARD_CYCLES=2, RST_CYCLES=3). Directed scenarios followed by
//               randomized stimulus against a time-since-commit reference
//               model. With TT_PROJ_SEL_SYNC_EN defined every input effect
//               is expected two cycles later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tt_proj_sel_ctrl;

    localparam int NP = 4;
    localparam int G  = 2;
    localparam int R  = 3;
`ifdef TT_PROJ_SEL_SYNC_EN
    localparam int L  = 2;
`else
    localparam int L  = 0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          ctrl_ena;
    logic          sel_clr;
    logic          sel_inc;
    logic          sel_commit;
    logic [NP-1:0] proj_ena;
    logic          proj_rst_n;
    logic [1:0]    active_addr;
    logic [1:0]    pending_addr;
    logic          busy;

    tt_proj_sel_ctrl #(
        .NUM_PROJ     (NP),
        .GUARD_CYCLES (G),
        .RST_CYCLES   (R)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ctrl_ena     (ctrl_ena),
        .sel_clr      (sel_clr),
        .sel_inc      (sel_inc),
        .sel_commit   (sel_commit),
        .proj_ena     (proj_ena),
        .proj_rst_n   (proj_rst_n),
        .active_addr  (active_addr),
        .pending_addr (pending_addr),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: outputs derived from the number of clocks since the
    // last accepted commit and the address sampled at that commit.
    // ------------------------------------------------------------------------
    bit     d1[4];
    bit     d2[4];
    bit     m_prev_inc;
    bit     m_prev_com;
    int     m_pending;
    int     m_active;
    int     m_tgt;
    bit     m_live;
    longint m_cyc;
    longint m_commit_cyc;

    int            zero_run  = 0;
    bit            seen_ena  = 1'b0;
    logic [NP-1:0] prev_ena  = '0;

    function automatic void model_edge();
        bit raw[4];
        bit eff[4];
        bit inc_rise;
        bit com_rise;
        int old_p;
        raw = '{ctrl_ena, sel_clr, sel_inc, sel_commit};
        if (!rst_n) begin
            for (int k = 0; k < 4; k++) begin
                d1[k] = 1'b0;
                d2[k] = 1'b0;
            end
            m_prev_inc   = 1'b0;
            m_prev_com   = 1'b0;
            m_pending    = 0;
            m_active     = 0;
            m_tgt        = 0;
            m_live       = 1'b0;
            m_cyc        = 0;
            m_commit_cyc = 0;
            return;
        end
        for (int k = 0; k < 4; k++) begin
            if (L == 2) begin
                eff[k] = d2[k];
                d2[k]  = d1[k];
                d1[k]  = raw[k];
            end else begin
                eff[k] = raw[k];
            end
        end
        inc_rise   = eff[2] && !m_prev_inc;
        com_rise   = eff[3] && !m_prev_com;
        m_prev_inc = eff[2];
        m_prev_com = eff[3];
        old_p      = m_pending;
        if (eff[1])        m_pending = 0;
        else if (inc_rise) m_pending = (m_pending + 1) % NP;
        m_cyc++;
        if (!eff[0]) begin
            m_live = 1'b0;
        end else if (com_rise) begin
            m_live       = 1'b1;
            m_commit_cyc = m_cyc - 1;
            m_tgt        = old_p;
        end
        if (m_live && (m_cyc - m_commit_cyc) == G + 1) m_active = m_tgt;
    endfunction

    // One clock: update model at the edge, then compare just after it
    task automatic step();
        longint      e;
        bit          drain;
        bit          hold;
        bit          run;
        logic [31:0] exp_ena;
        @(posedge clk);
        model_edge();
        #1;
        e       = m_cyc - m_commit_cyc;
        drain   = m_live && (e <= G);
        hold    = m_live && (e > G) && (e <= G + R);
        run     = m_live && (e > G + R);
        exp_ena = (hold || run) ? (32'd1 << m_active) : 32'd0;
        check("proj_ena",     32'(proj_ena),     exp_ena);
        check("proj_rst_n",   32'(proj_rst_n),   32'(run));
        check("busy",         32'(busy),         32'(drain || hold));
        check("active_addr",  32'(active_addr),  32'(m_active));
        check("pending_addr", 32'(pending_addr), 32'(m_pending));
        check("ena_onehot",   32'($countones(proj_ena) <= 1), 32'd1);
        if (proj_ena == '0) begin
            zero_run++;
        end else begin
            if (prev_ena == '0 && seen_ena)
                check("guard_gap", 32'(zero_run >= G), 32'd1);
            else if (prev_ena != '0 && proj_ena != prev_ena)
                check("ena_direct_switch", 32'(proj_ena), 32'(prev_ena));
            seen_ena = 1'b1;
            zero_run = 0;
        end
        prev_ena = proj_ena;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_inc();
        sel_inc = 1'b1;
        step();
        sel_inc = 1'b0;
        step();
    endtask

    task automatic pulse_clr();
        sel_clr = 1'b1;
        step();
        sel_clr = 1'b0;
        idle(L);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int zeros;
        int jj;
        rst_n      = 1'b0;
        ctrl_ena   = 1'b0;
        sel_clr    = 1'b0;
        sel_inc    = 1'b0;
        sel_commit = 1'b0;

        // Case 1: reset values, two increments, commit and switch timing
        idle(2);
        check("rst_ena",     32'(proj_ena),     32'd0);
        check("rst_rst_n",   32'(proj_rst_n),   32'd0);
        check("rst_active",  32'(active_addr),  32'd0);
        check("rst_pending", 32'(pending_addr), 32'd0);
        check("rst_busy",    32'(busy),         32'd0);
        rst_n    = 1'b1;
        ctrl_ena = 1'b1;
        idle(L + 1);
        pulse_inc();
        pulse_inc();
        idle(L);
        check("c1_pending", 32'(pending_addr), 32'd2);
        sel_commit = 1'b1;
        for (int j = 1; j <= L + 8; j++) begin
            step();
            sel_commit = 1'b0;
            jj = j - L;
            if (j > L) begin
                check("c1_ena",   32'(proj_ena),   (jj >= 3) ? 32'h4 : 32'h0);
                check("c1_rst_n", 32'(proj_rst_n), (jj >= 6) ? 32'd1 : 32'd0);
            end
        end
        check("c1_active", 32'(active_addr), 32'd2);

        // Case 2: increment wrap and clear-over-increment priority
        pulse_clr();
        repeat (5) pulse_inc();
        idle(L);
        check("c2_wrap", 32'(pending_addr), 32'd1);
        sel_inc = 1'b1;
        sel_clr = 1'b1;
        step();
        sel_clr = 1'b0;
        idle(L + 2);
        sel_inc = 1'b0;
        check("c2_clr_wins", 32'(pending_addr), 32'd0);

        // Case 3: switch from project 2 to project 1 with a guard gap
        pulse_clr();
        pulse_inc();
        idle(L);
        sel_commit = 1'b1;
        zeros = 0;
        for (int j = 1; j <= L + 8; j++) begin
            step();
            sel_commit = 1'b0;
            if (proj_ena == '0) zeros++;
        end
        check("c3_gap_len", 32'(zeros),    32'(G));
        check("c3_new_ena", 32'(proj_ena), 32'h2);

        // Case 4: retarget to project 3 while the first switch is in HOLD
        pulse_clr();
        pulse_inc();
        pulse_inc();
        idle(L);
        sel_commit = 1'b1;
        step();
        sel_commit = 1'b0;
        step();
        sel_inc = 1'b1;
        step();
        sel_inc = 1'b0;
        step();
        sel_commit = 1'b1;
        for (int j = 1; j <= L + 7; j++) begin
            step();
            sel_commit = 1'b0;
            jj = j - L;
            if (j > L) begin
                check("c4_ena",   32'(proj_ena),   (jj >= 3) ? 32'h8 : 32'h0);
                check("c4_rst_n", 32'(proj_rst_n), (jj >= 6) ? 32'd1 : 32'd0);
            end
        end

        // Case 5: disable in RUN, commits ignored while disabled, no auto-restart
        idle(2);
        ctrl_ena = 1'b0;
        idle(L + 1);
        check("c5_ena",   32'(proj_ena),   32'd0);
        check("c5_rst_n", 32'(proj_rst_n), 32'd0);
        sel_commit = 1'b1;
        step();
        sel_commit = 1'b0;
        idle(L + 4);
        check("c5_commit_ignored", 32'(proj_ena), 32'd0);
        ctrl_ena = 1'b1;
        idle(L + 6);
        check("c5_no_restart", 32'(proj_ena | NP'(busy)), 32'd0);

        // Case 6: reset while draining
        pulse_clr();
        pulse_inc();
        idle(L);
        sel_commit = 1'b1;
        step();
        sel_commit = 1'b0;
        idle(L);
        check("c6_in_drain", 32'(busy), 32'd1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("c6_ena",     32'(proj_ena),     32'd0);
        check("c6_rst_n",   32'(proj_rst_n),   32'd0);
        check("c6_active",  32'(active_addr),  32'd0);
        check("c6_pending", 32'(pending_addr), 32'd0);
        check("c6_busy",    32'(busy),         32'd0);

        // Randomized phase against the reference model
        ctrl_ena = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            rst_n = ($urandom_range(0, 199) != 0);
            if (ctrl_ena) ctrl_ena = ($urandom_range(0, 59) != 0);
            else          ctrl_ena = ($urandom_range(0, 7) == 0);
            sel_clr    = ($urandom_range(0, 15) == 0);
            sel_inc    = 1'($urandom_range(0, 1));
            sel_commit = ($urandom_range(0, 11) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
